// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - instruction-fetch stage: PC register, imem request, one-entry skid buffer, IF/ID register
module pc_fetch_stage #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  next_pc,
    output logic [7:0]  pc,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [7:0]  redirect_pc,
    output logic        ifid_valid,
    output logic [7:0]  ifid_pc,
    output logic [31:0] ifid_instr
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Every PC load is word aligned, whatever the source.
    localparam logic [7:0] ALIGN_MASK       = 8'hFC;
    localparam logic [7:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    state_t      state;
    state_t      state_next;

    logic [7:0]  pc_next;
    logic        ifid_valid_next;
    logic [7:0]  ifid_pc_next;
    logic [31:0] ifid_instr_next;

    // Skid buffer: only meaningful while in HOLD, so no separate valid bit.
    logic [7:0]  skid_pc;
    logic [31:0] skid_instr;
    logic [7:0]  skid_pc_next;
    logic [31:0] skid_instr_next;

    logic        can_load;
    logic        consumed;

    assign can_load = !ifid_valid || !stall;
    assign consumed = ifid_valid && !stall;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath next values and fetch request; flush overrides everything.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        ifid_valid_next = ifid_valid;
        ifid_pc_next    = ifid_pc;
        ifid_instr_next = ifid_instr;
        skid_pc_next    = skid_pc;
        skid_instr_next = skid_instr;
        imem_req        = (state == REQ);
        imem_addr       = pc;

        // A consumed entry empties the slot unless something below refills it.
        if (consumed) begin
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
        end

        unique case (state)
            REQ: begin
                if (imem_ready) begin
                    pc_next = next_pc & ALIGN_MASK;
                    if (can_load) begin
                        ifid_valid_next = 1'b1;
                        ifid_pc_next    = pc;
                        ifid_instr_next = imem_rdata;
                    end else begin
                        skid_pc_next    = pc;
                        skid_instr_next = imem_rdata;
                        state_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (can_load) begin
                    ifid_valid_next = 1'b1;
                    ifid_pc_next    = skid_pc;
                    ifid_instr_next = skid_instr;
                    state_next      = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase

        // Taken branch: drop the slot, the buffer and any word returned this cycle.
        if (flush) begin
            state_next      = REQ;
            pc_next         = redirect_pc & ALIGN_MASK;
            ifid_valid_next = 1'b0;
            ifid_pc_next    = 8'h00;
            ifid_instr_next = NOP_INSTR;
            skid_pc_next    = 8'h00;
            skid_instr_next = NOP_INSTR;
        end
    end

    // PC, IF/ID and skid buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC_ALIGNED;
            ifid_valid <= 1'b0;
            ifid_pc    <= 8'h00;
            ifid_instr <= NOP_INSTR;
            skid_pc    <= 8'h00;
            skid_instr <= NOP_INSTR;
        end else begin
            pc         <= pc_next;
            ifid_valid <= ifid_valid_next;
            ifid_pc    <= ifid_pc_next;
            ifid_instr <= ifid_instr_next;
            skid_pc    <= skid_pc_next;
            skid_instr <= skid_instr_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - scoreboard bench for pc_fetch_stage
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  next_pc = 8'h00;
    logic [7:0]  pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        ifid_valid;
    logic [7:0]  ifid_pc;
    logic [31:0] ifid_instr;

    int errors = 0;
    int checks = 0;

    // Bench model: expected PC, FSM hold flag, slot valid, and a queue of
    // {pc, instr} entries in program order (front = IF/ID, second = skid).
    logic [7:0]  m_pc = 8'h00;
    logic        m_hold = 1'b0;
    logic        m_valid = 1'b0;
    logic [39:0] sb[$];
    logic [1:0]  np_junk = 2'b00;

    pc_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'hC0, a, 8'h5A, ~a};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Advance one clock: update the model from the driven inputs, then
    // compare the DUT against the scoreboard at the falling edge.
    task automatic cycle();
        logic cons;
        logic cl;
        next_pc = (m_pc + 8'd4) | {6'd0, np_junk};
        if (!rst_n) begin
            m_pc = 8'h00; m_hold = 1'b0; m_valid = 1'b0; sb.delete();
        end else if (flush) begin
            m_pc = redirect_pc & 8'hFC; m_hold = 1'b0; m_valid = 1'b0; sb.delete();
        end else begin
            cons = m_valid && !stall;
            cl   = !m_valid || !stall;
            if (cons) void'(sb.pop_front());
            if (!m_hold) begin
                if (imem_ready) begin
                    sb.push_back({m_pc, mem_word(m_pc)});
                    m_pc = next_pc & 8'hFC;
                    if (cl) m_valid = 1'b1;
                    else    m_hold = 1'b1;
                end else if (cons) begin
                    m_valid = 1'b0;
                end
            end else if (cl) begin
                m_hold = 1'b0;
                m_valid = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifid_valid !== m_valid) begin
            errors++; $display("FAIL sb_valid: got %b expected %b", ifid_valid, m_valid);
        end
        checks++;
        if (pc !== m_pc) begin
            errors++; $display("FAIL sb_pc: got %h expected %h", pc, m_pc);
        end
        checks++;
        if (imem_req !== !m_hold) begin
            errors++; $display("FAIL sb_req: got %b expected %b", imem_req, !m_hold);
        end
        if (m_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL sb_empty: got valid entry expected none");
            end else if ({ifid_pc, ifid_instr} !== sb[0]) begin
                errors++; $display("FAIL sb_entry: got %h expected %h", {ifid_pc, ifid_instr}, sb[0]);
            end
        end else begin
            checks++;
            if (ifid_instr !== NOP) begin
                errors++; $display("FAIL sb_nop: got %h expected %h", ifid_instr, NOP);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0; np_junk = 2'b00;
        cycle();
        rst_n = 1'b1;
    endtask

    // Fetch 00 and 04, then stall while 08 returns so it lands in the skid buffer.
    task automatic reach_hold();
        do_reset();
        imem_ready = 1'b1;
        cycle();
        cycle();
        stall = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++;
        if (ifid_pc !== 8'h00) begin errors++; $display("FAIL reset_ifid_pc: got %h expected 00", ifid_pc); end
        checks++;
        if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
            errors++; $display("FAIL reset_slot: got %b/%h expected 0/%h", ifid_valid, ifid_instr, NOP);
        end
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_streaming();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if ({ifid_valid, ifid_pc} !== {1'b1, 8'(i * 4)}) begin
                errors++; $display("FAIL stream_%0d: got %b/%h expected 1/%h", i, ifid_valid, ifid_pc, 8'(i * 4));
            end
        end
    endtask

    task automatic test_slow_memory();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({imem_addr, pc, ifid_valid} !== {8'h00, 8'h00, 1'b0}) begin
                errors++; $display("FAIL slow_wait_%0d: got %h/%h/%b expected 00/00/0", i, imem_addr, pc, ifid_valid);
            end
        end
        imem_ready = 1'b1;
        cycle();
        imem_ready = 1'b0;
        checks++;
        if ({ifid_valid, ifid_pc} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL slow_first: got %b/%h expected 1/00", ifid_valid, ifid_pc);
        end
        cycle();
    endtask

    task automatic test_stall_skid();
        reach_hold();
        checks++;
        if ({imem_req, ifid_pc} !== {1'b0, 8'h04}) begin
            errors++; $display("FAIL skid_hold: got %b/%h expected 0/04", imem_req, ifid_pc);
        end
        cycle();
        stall = 1'b0;
        cycle();
        checks++;
        if ({ifid_valid, ifid_pc, imem_addr} !== {1'b1, 8'h08, 8'h0C}) begin
            errors++; $display("FAIL skid_release: got %b/%h/%h expected 1/08/0C", ifid_valid, ifid_pc, imem_addr);
        end
        cycle();
        checks++;
        if (ifid_pc !== 8'h0C) begin errors++; $display("FAIL skid_resume: got %h expected 0C", ifid_pc); end
    endtask

    task automatic test_flush();
        reach_hold();
        flush = 1'b1; redirect_pc = 8'h41;
        cycle();
        flush = 1'b0;
        checks++;
        if ({ifid_valid, ifid_instr, ifid_pc} !== {1'b0, NOP, 8'h00}) begin
            errors++; $display("FAIL flush_slot: got %b/%h/%h expected 0/%h/00", ifid_valid, ifid_instr, ifid_pc, NOP);
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h40}) begin
            errors++; $display("FAIL flush_addr: got %b/%h expected 1/40", imem_req, imem_addr);
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (ifid_pc !== 8'h40) begin errors++; $display("FAIL flush_target: got %h expected 40", ifid_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        flush = 1'b1; redirect_pc = 8'hFE;
        cycle();
        flush = 1'b0; imem_ready = 1'b1;
        cycle();
        checks++;
        if ({ifid_valid, ifid_pc} !== {1'b1, 8'hFC}) begin
            errors++; $display("FAIL wrap_fc: got %b/%h expected 1/FC", ifid_valid, ifid_pc);
        end
        cycle();
        checks++;
        if ({ifid_valid, ifid_pc} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL wrap_00: got %b/%h expected 1/00", ifid_valid, ifid_pc);
        end
    endtask

    task automatic test_reset_mid_hold();
        reach_hold();
        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
        checks++;
        if ({pc, ifid_valid, ifid_pc, ifid_instr, imem_req} !== {8'h00, 1'b0, 8'h00, NOP, 1'b1}) begin
            errors++; $display("FAIL midreset: got %h/%b/%h/%h/%b expected 00/0/00/%h/1",
                               pc, ifid_valid, ifid_pc, ifid_instr, imem_req, NOP);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (ifid_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_leak_%0d: got %b/%h expected 0", i, ifid_valid, ifid_pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            imem_ready  = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 2) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom_range(0, 255));
            np_junk     = 2'($urandom_range(0, 3));
            cycle();
        end
        flush = 1'b0; stall = 1'b0; imem_ready = 1'b0; np_junk = 2'b00;
        cycle();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_slow_memory();
        test_stall_skid();
        test_flush();
        test_wrap();
        test_reset_mid_hold();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
